// File: rtl/led_panel_receiver.sv
// LED panel receiver: shifts 12 serial colour lanes, latches them to column outputs and decodes rows.
// Optional protocol error flags are built only when LED_PANEL_RX_ERR_CHECK_EN is defined.
module led_panel_receiver #(
    parameter int unsigned CHAIN_LEN = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     serial_clk,
    input  logic                     latch_enable,
    input  logic                     output_enable_n,
    input  logic [3:0]               serial_data_in_red,
    input  logic [3:0]               serial_data_in_green,
    input  logic [3:0]               serial_data_in_blue,
    input  logic [15:0]              row_select_n,
    output logic [4*CHAIN_LEN-1:0]   col_red,
    output logic [4*CHAIN_LEN-1:0]   col_green,
    output logic [4*CHAIN_LEN-1:0]   col_blue,
    output logic                     col_enable,
    output logic                     latch_pulse,
    output logic [6:0]               bit_count,
    output logic [3:0]               row_index,
    output logic                     row_active,
    output logic [15:0]              frame_count,
    output logic                     err_bit_count,
    output logic                     err_row_multi
);

    // Packed so that lane k lands at bits [k*CHAIN_LEN +: CHAIN_LEN] when flattened.
    typedef logic [3:0][CHAIN_LEN-1:0] lanes_t;

    lanes_t      sr_red_q, sr_red_d;
    lanes_t      sr_green_q, sr_green_d;
    lanes_t      sr_blue_q, sr_blue_d;
    lanes_t      col_red_q, col_green_q, col_blue_q;
    logic        sclk_prev_q, latch_prev_q;
    logic        sclk_edge, latch_edge;
    logic        col_enable_q, latch_pulse_q;
    logic [6:0]  bit_count_q, bit_count_d;
    logic [3:0]  row_index_q, row_index_d;
    logic        row_active_q;
    logic [15:0] frame_count_q;
    logic [15:0] row_zeros;
    logic        row_one;
    logic [3:0]  row_pos;
    logic        frame_inc;

    assign sclk_edge  = serial_clk & ~sclk_prev_q;
    assign latch_edge = latch_enable & ~latch_prev_q;

    always_comb begin
        sr_red_d   = sr_red_q;
        sr_green_d = sr_green_q;
        sr_blue_d  = sr_blue_q;
        if (sclk_edge) begin
            for (int l = 0; l < 4; l++) begin
                sr_red_d[l]   = (sr_red_q[l] << 1)   | CHAIN_LEN'(serial_data_in_red[l]);
                sr_green_d[l] = (sr_green_q[l] << 1) | CHAIN_LEN'(serial_data_in_green[l]);
                sr_blue_d[l]  = (sr_blue_q[l] << 1)  | CHAIN_LEN'(serial_data_in_blue[l]);
            end
        end
    end

    // A shift coinciding with a latch is the first bit of the next word.
    always_comb begin
        bit_count_d = bit_count_q;
        if (latch_edge) begin
            bit_count_d = {6'd0, sclk_edge};
        end else if (sclk_edge && bit_count_q != 7'd127) begin
            bit_count_d = bit_count_q + 7'd1;
        end
    end

    always_comb begin
        row_zeros = ~row_select_n;
        row_one   = (row_zeros != 16'd0) && ((row_zeros & (row_zeros - 16'd1)) == 16'd0);
        row_pos   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (row_zeros[i]) begin
                row_pos = 4'(i);
            end
        end
        row_index_d = row_one ? row_pos : row_index_q;
        frame_inc   = row_one && (row_index_q == 4'd15) && (row_pos == 4'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_red_q      <= '0;
            sr_green_q    <= '0;
            sr_blue_q     <= '0;
            col_red_q     <= '0;
            col_green_q   <= '0;
            col_blue_q    <= '0;
            sclk_prev_q   <= 1'b0;
            latch_prev_q  <= 1'b0;
            col_enable_q  <= 1'b0;
            latch_pulse_q <= 1'b0;
            bit_count_q   <= 7'd0;
            row_index_q   <= 4'd0;
            row_active_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            sr_red_q      <= sr_red_d;
            sr_green_q    <= sr_green_d;
            sr_blue_q     <= sr_blue_d;
            if (latch_edge) begin
                col_red_q   <= sr_red_q;
                col_green_q <= sr_green_q;
                col_blue_q  <= sr_blue_q;
            end
            sclk_prev_q   <= serial_clk;
            latch_prev_q  <= latch_enable;
            col_enable_q  <= ~output_enable_n;
            latch_pulse_q <= latch_edge;
            bit_count_q   <= bit_count_d;
            row_index_q   <= row_index_d;
            row_active_q  <= row_one;
            if (frame_inc) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

`ifdef LED_PANEL_RX_ERR_CHECK_EN
    localparam logic [6:0] ChainLenBits = 7'(CHAIN_LEN);

    logic err_bit_count_q, err_row_multi_q;
    logic row_multi;

    assign row_multi = (row_zeros & (row_zeros - 16'd1)) != 16'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_bit_count_q <= 1'b0;
            err_row_multi_q <= 1'b0;
        end else begin
            if (latch_edge) begin
                err_bit_count_q <= (bit_count_q != ChainLenBits);
            end
            if (row_multi) begin
                err_row_multi_q <= 1'b1;
            end
        end
    end

    assign err_bit_count = err_bit_count_q;
    assign err_row_multi = err_row_multi_q;
`else
    assign err_bit_count = 1'b0;
    assign err_row_multi = 1'b0;
`endif

    assign col_red     = col_red_q;
    assign col_green   = col_green_q;
    assign col_blue    = col_blue_q;
    assign col_enable  = col_enable_q;
    assign latch_pulse = latch_pulse_q;
    assign bit_count   = bit_count_q;
    assign row_index   = row_index_q;
    assign row_active  = row_active_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/led_panel_receiver.md
LED_PANEL_RECEIVER -- requirements
Module: led_panel_receiver

Interface
REQ-001 Parameter: CHAIN_LEN, default 16, shift-register length per colour lane; legal range 1..64.
REQ-002 Port: clk  in  1  system clock, 50 MHz; all logic is on its rising edge.
REQ-003 Port: reset_n  in  1  reset; asynchronous assert, active-low.
REQ-004 Port: serial_clk  in  1  panel shift clock, sampled on clk.
REQ-005 Port: latch_enable  in  1  panel latch strobe, sampled on clk.
REQ-006 Port: output_enable_n  in  1  panel output enable, active-low.
REQ-007 Port: serial_data_in_red / _green / _blue  in  4 each  one serial bit per lane per colour.
REQ-008 Port: row_select_n  in  16  active-low row drive.
REQ-009 Port: col_red / col_green / col_blue  out  4*CHAIN_LEN each  latched column data; lane k occupies bits [k*CHAIN_LEN +: CHAIN_LEN].
REQ-010 Port: col_enable  out  1  registered ~output_enable_n.
REQ-011 Port: latch_pulse  out  1  one-cycle strobe; high in the cycle col_* update.
REQ-012 Port: bit_count  out  7  number of shifts since the last latch.
REQ-013 Port: row_index  out  4  index of the active row.
REQ-014 Port: row_active  out  1  exactly one row_select_n bit is low.
REQ-015 Port: frame_count  out  16  completed-frame counter.
REQ-016 Port: err_bit_count, err_row_multi  out  1 each  protocol error flags.

Function
REQ-017 The block SHALL register serial_clk and latch_enable once (prev copies); an edge is a cycle where input=1 and prev=0.
REQ-018 On each serial_clk edge, every one of the 12 lane shift registers SHALL shift toward the MSB and load that cycle's data bit into bit 0.
REQ-019 On each latch_enable edge, col_* SHALL load the shift-register contents as they were before any same-cycle shift; latch_pulse SHALL be 1 for exactly that cycle.
REQ-020 A serial_clk edge coincident with a latch edge SHALL still shift; the shifted bit counts toward the next latch.
REQ-021 bit_count SHALL increment on each shift and saturate at 127.
REQ-022 On a latch, bit_count SHALL become 0, or 1 if a shift coincides with the latch.
REQ-023 On each latch, err_bit_count SHALL be set to 1 if the pre-latch bit_count differs from CHAIN_LEN, else cleared to 0.
REQ-024 col_enable SHALL follow ~output_enable_n with 1 cycle latency.
REQ-025 Each cycle, row decode SHALL register row_active = (exactly one bit of row_select_n is 0).
REQ-026 When row_active is computed true, row_index SHALL take that bit's position; otherwise row_index SHALL hold its value.
REQ-027 err_row_multi SHALL go to 1 when two or more row_select_n bits are 0 in a cycle, and SHALL remain sticky until reset.
REQ-028 frame_count SHALL increment by 1 when row_index changes from 15 to 0 while row_active is true, and SHALL wrap from 65535 to 0.
REQ-029 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-030 While reset_n=0: shift registers, col_*, col_enable, latch_pulse, bit_count, row_index, row_active, frame_count, err_* and the prev copies SHALL all be 0.
REQ-031 Reset asserted mid-shift or mid-frame SHALL discard partial data.
REQ-032 After reset release, the first latch SHALL flag err_bit_count unless CHAIN_LEN shifts preceded it.

Configuration
REQ-033 Macro LED_PANEL_RX_ERR_CHECK_EN: when defined, err_bit_count and err_row_multi behave per REQ-023/REQ-027.
REQ-034 When the macro is undefined, err_bit_count and err_row_multi SHALL be constant 0, with no error logic synthesised; all other behaviour is unchanged.

Verification
REQ-035 CHAIN_LEN=16; drive 16 serial_clk pulses with red lane0 data 1,0,0,...,0, then latch -> col_red[15:0]=16'h8000, latch_pulse 1 cycle, err_bit_count=0, bit_count=0.
REQ-036 Only 15 shifts, then latch -> err_bit_count=1; next latch after exactly 16 shifts -> err_bit_count=0.
REQ-037 serial_clk rise coincident with latch rise after 16 shifts -> col_* hold the pre-shift data; bit_count=1; err_bit_count=0.
REQ-038 row_select_n walks 16'hFFFE..16'h7FFF, then 16'hFFFE -> row_index 0..15 then 0, frame_count=1, row_active=1 throughout.
REQ-039 row_select_n=16'hFFFC -> err_row_multi=1 and row_active=0 next cycle; row_index unchanged; flag persists after row_select_n=16'hFFFE.
REQ-040 reset_n pulsed low after 8 shifts with output_enable_n=0 -> all outputs 0 immediately; next latch after 16 shifts -> clean data, err_bit_count=0.
